// File: rtl/adc_par_pkg.sv
// rtl/adc_par_pkg.sv - shared state encoding, default ADC config words and width helper
package adc_par_pkg;

   typedef enum logic [2:0] {
      RST_ADC = 3'd0,
      CFG_WR  = 3'd1,
      IDLE    = 3'd2,
      CONV    = 3'd3,
      WAIT_BH = 3'd4,
      WAIT_BL = 3'd5,
      READ    = 3'd6
   } state_t;

   localparam logic [15:0] CFG_HI_DEF = 16'h8054;
   localparam logic [15:0] CFG_LO_DEF = 16'h03FF;
   localparam int          RST_CYC    = 4;

   function automatic int chw(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// rtl/adc_tick_gen.sv - conversion tick divider; ADC_TIMESTAMP_EN adds a 32-bit tick count
module adc_tick_gen #(
   parameter int SAMPLE_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        tick
`ifdef ADC_TIMESTAMP_EN
   ,
   output logic [31:0] ts
`endif
);
   localparam int            DW       = $clog2(SAMPLE_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

   logic [DW-1:0] div_q, div_d;

   always_comb begin
      div_d = div_q;
      tick  = 1'b0;
      if (run) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            tick  = 1'b1;
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) div_q <= '0;
      else     div_q <= div_d;
   end

`ifdef ADC_TIMESTAMP_EN
   logic [31:0] ts_q, ts_d;

   always_comb begin
      ts_d = ts_q;
      if (tick) ts_d = ts_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_d;
   end

   assign ts = ts_q;
`endif

endmodule

// File: rtl/adc_par_sampler.sv
// rtl/adc_par_sampler.sv - ADS85x8 parallel-bus config writer and periodic frame sampler
// Optional ADC_TIMESTAMP_EN adds sample_ts, the tick count latched at each conversion start.
module adc_par_sampler
   import adc_par_pkg::*;
#(
   parameter int                N_CH        = 8,
   parameter int                DATA_W      = 16,
   parameter logic [DATA_W-1:0] CFG_HI      = DATA_W'(CFG_HI_DEF),
   parameter logic [DATA_W-1:0] CFG_LO      = DATA_W'(CFG_LO_DEF),
   parameter int                WR_LOW_CYC  = 4,
   parameter int                RD_LOW_CYC  = 3,
   parameter int                RD_HIGH_CYC = 2,
   parameter int                CONVST_CYC  = 4,
   parameter int                SAMPLE_DIV  = 1000,
   parameter int                BUSY_TO     = 512
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    Busy,
   inout  wire  [DATA_W-1:0]       DB,
   output logic [N_CH/2-1:0]       convst,
   output logic                    CS_N,
   output logic                    RD_N,
   output logic                    WR_N,
   output logic                    HW_N,
   output logic                    PAR_N,
   output logic                    STBY_N,
   output logic                    ADCrst,
   output logic [DATA_W-1:0]       sample_data,
   output logic [chw(N_CH)-1:0]    sample_ch,
   output logic                    sample_valid,
   output logic                    sample_last,
   output logic                    cfg_done,
   output logic                    busy_err,
   output logic                    overrun,
   output logic [2:0]              state_ff
`ifdef ADC_TIMESTAMP_EN
   ,
   output logic [31:0]             sample_ts
`endif
);
   localparam int               CH_W      = chw(N_CH);
   localparam int               CNT_W     = 16;
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] WR_HI     = CNT_W'(WR_LOW_CYC);
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONVST_CYC - 1);
   localparam logic [CNT_W-1:0] BUSY_LIM  = CNT_W'(BUSY_TO + 1);
   localparam logic [CNT_W-1:0] RD_SAMP   = CNT_W'(RD_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LOW_CYC + RD_HIGH_CYC - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                word_q, word_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                busy_m_q, busy_m_d, busy_s_q, busy_s_d;
   logic                cfg_done_q, cfg_done_d, busy_err_q, busy_err_d, overrun_q, overrun_d;
   logic [DATA_W-1:0]   sample_data_q, sample_data_d;
   logic [CH_W-1:0]     sample_ch_q, sample_ch_d;
   logic                sample_valid_q, sample_valid_d, sample_last_q, sample_last_d;
   logic                cs_n, rd_n, wr_n, conv, db_oe, adc_rst, tick;

`ifdef ADC_TIMESTAMP_EN
   logic [31:0] ts_cnt, sample_ts_q, sample_ts_d;
`endif

   adc_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (cfg_done_q & en),
      .tick (tick)
`ifdef ADC_TIMESTAMP_EN
      ,
      .ts   (ts_cnt)
`endif
   );

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      word_d         = word_q;
      ch_d           = ch_q;
      busy_m_d       = Busy;
      busy_s_d       = busy_m_q;
      cfg_done_d     = cfg_done_q;
      busy_err_d     = 1'b0;
      overrun_d      = tick && (state_q != IDLE);
      sample_data_d  = sample_data_q;
      sample_ch_d    = sample_ch_q;
      sample_valid_d = 1'b0;
      sample_last_d  = 1'b0;
`ifdef ADC_TIMESTAMP_EN
      sample_ts_d    = sample_ts_q;
`endif
      cs_n    = 1'b1;
      rd_n    = 1'b1;
      wr_n    = 1'b1;
      conv    = 1'b0;
      db_oe   = 1'b0;
      adc_rst = 1'b0;
      case (state_q)
         RST_ADC: begin
            adc_rst = 1'b1;
            if (cnt_q == RST_LAST) begin
               state_d = CFG_WR;
               cnt_d   = '0;
               word_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CFG_WR: begin
            cs_n  = 1'b0;
            db_oe = 1'b1;
            wr_n  = (cnt_q == WR_HI);
            if (cnt_q == WR_HI) begin
               cnt_d = '0;
               if (word_q) begin
                  cfg_done_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  word_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IDLE: begin
            if (tick) begin
               state_d = CONV;
               cnt_d   = '0;
`ifdef ADC_TIMESTAMP_EN
               sample_ts_d = ts_cnt;
`endif
            end
         end
         CONV: begin
            conv = 1'b1;
            if (cnt_q == CONV_LAST) begin
               state_d = WAIT_BH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_BH, WAIT_BL: begin
            // The edge we wait for wins over a timeout landing on the same cycle.
            if (busy_s_q == (state_q == WAIT_BH)) begin
               state_d = (state_q == WAIT_BH) ? WAIT_BL : READ;
               cnt_d   = '0;
               ch_d    = '0;
            end else if (cnt_q == BUSY_LIM) begin
               busy_err_d = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         READ: begin
            cs_n = 1'b0;
            rd_n = (cnt_q > RD_SAMP);
            if (cnt_q == RD_SAMP) begin
               sample_data_d  = DB;
               sample_ch_d    = ch_q;
               sample_valid_d = 1'b1;
               sample_last_d  = (ch_q == CH_LAST);
            end
            if (cnt_q == RD_LAST) begin
               cnt_d = '0;
               if (ch_q == CH_LAST) begin
                  ch_d    = '0;
                  state_d = IDLE;
               end else begin
                  ch_d = ch_q + CH_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RST_ADC;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RST_ADC;
         cnt_q          <= '0;
         word_q         <= 1'b0;
         ch_q           <= '0;
         busy_m_q       <= 1'b0;
         busy_s_q       <= 1'b0;
         cfg_done_q     <= 1'b0;
         busy_err_q     <= 1'b0;
         overrun_q      <= 1'b0;
         sample_data_q  <= '0;
         sample_ch_q    <= '0;
         sample_valid_q <= 1'b0;
         sample_last_q  <= 1'b0;
`ifdef ADC_TIMESTAMP_EN
         sample_ts_q    <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         word_q         <= word_d;
         ch_q           <= ch_d;
         busy_m_q       <= busy_m_d;
         busy_s_q       <= busy_s_d;
         cfg_done_q     <= cfg_done_d;
         busy_err_q     <= busy_err_d;
         overrun_q      <= overrun_d;
         sample_data_q  <= sample_data_d;
         sample_ch_q    <= sample_ch_d;
         sample_valid_q <= sample_valid_d;
         sample_last_q  <= sample_last_d;
`ifdef ADC_TIMESTAMP_EN
         sample_ts_q    <= sample_ts_d;
`endif
      end
   end

   // DB is only ever driven while the config words are being written.
   assign DB           = db_oe ? (word_q ? CFG_LO : CFG_HI) : {DATA_W{1'bz}};
   assign convst       = {(N_CH/2){conv}};
   assign CS_N         = cs_n;
   assign RD_N         = rd_n;
   assign WR_N         = wr_n;
   assign HW_N         = 1'b1;
   assign PAR_N        = 1'b0;
   assign STBY_N       = 1'b1;
   assign ADCrst       = adc_rst;
   assign sample_data  = sample_data_q;
   assign sample_ch    = sample_ch_q;
   assign sample_valid = sample_valid_q;
   assign sample_last  = sample_last_q;
   assign cfg_done     = cfg_done_q;
   assign busy_err     = busy_err_q;
   assign overrun      = overrun_q;
   assign state_ff     = state_q;
`ifdef ADC_TIMESTAMP_EN
   assign sample_ts    = sample_ts_q;
`endif

endmodule

// File: tb/tb_adc_par_sampler.sv
// tb/tb_adc_par_sampler.sv - directed bench for adc_par_sampler with a small ADS85x8 pin model
`timescale 1ns/1ps
module tb_adc_par_sampler;
   localparam int N_CH = 8, DATA_W = 16, SAMPLE_DIV = 128, BUSY_TO = 200, BUSY_DLY = 20;

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, busy = 1'b0;
   wire  [DATA_W-1:0] db;
   logic [3:0]        convst;
   logic              cs_n, rd_n, wr_n, hw_n, par_n, stby_n, adc_rst;
   logic [DATA_W-1:0] sample_data;
   logic [2:0]        sample_ch, state_ff;
   logic              sample_valid, sample_last, cfg_done, busy_err, overrun;
`ifdef ADC_TIMESTAMP_EN
   logic [31:0]       sample_ts;
   logic [31:0]       bt_ts[$];
`endif

   int n_assert = 0, n_fail = 0, cyc = 0;
   bit no_busy = 1'b0;
   int busy_hi = 10;
   int bcnt = 0, rd_idx = 0;
   logic mconv_prev = 1'b0, rd_prev = 1'b1, conv_q = 1'b0;
   logic [2:0] st_prev = 3'd0;
   logic [DATA_W-1:0] model_word;
   logic [19:0] bt_q[$];
   int conv_cyc[$], wbh_cyc[$], err_cyc[$];
   int ovr_cnt = 0, viol = 0;

   adc_par_sampler #(.N_CH(N_CH), .DATA_W(DATA_W), .SAMPLE_DIV(SAMPLE_DIV), .BUSY_TO(BUSY_TO)) dut (
      .clk(clk), .rst(rst), .en(en), .Busy(busy), .DB(db), .convst(convst),
      .CS_N(cs_n), .RD_N(rd_n), .WR_N(wr_n), .HW_N(hw_n), .PAR_N(par_n), .STBY_N(stby_n),
      .ADCrst(adc_rst), .sample_data(sample_data), .sample_ch(sample_ch),
      .sample_valid(sample_valid), .sample_last(sample_last), .cfg_done(cfg_done),
      .busy_err(busy_err), .overrun(overrun), .state_ff(state_ff)
`ifdef ADC_TIMESTAMP_EN
      , .sample_ts(sample_ts)
`endif
   );

   always #5 clk = ~clk;

   // ADC model: Busy rises BUSY_DLY clk after convst, stays high busy_hi clk; word = 0x1000 + channel.
   assign model_word = 16'h1000 + rd_idx[15:0];
   assign db = (!cs_n && !rd_n) ? model_word : {DATA_W{1'bz}};

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      mconv_prev <= convst[0];
      if (convst[0] && !mconv_prev) bcnt <= 1;
      else if (bcnt != 0)           bcnt <= bcnt + 1;
      busy    <= !no_busy && (bcnt >= BUSY_DLY) && (bcnt < BUSY_DLY + busy_hi);
      rd_prev <= rd_n;
      if (cs_n)                rd_idx <= 0;
      else if (rd_n && !rd_prev) rd_idx <= rd_idx + 1;
   end

   always @(negedge clk) begin
      if (sample_valid) begin
         bt_q.push_back({sample_ch, sample_data, sample_last});
`ifdef ADC_TIMESTAMP_EN
         bt_ts.push_back(sample_ts);
`endif
      end
      if (convst[0] && !conv_q) conv_cyc.push_back(cyc);
      conv_q <= convst[0];
      if (state_ff == 3'd4 && st_prev != 3'd4) wbh_cyc.push_back(cyc);
      st_prev <= state_ff;
      if (busy_err) err_cyc.push_back(cyc);
      if (overrun)  ovr_cnt <= ovr_cnt + 1;
      if ((!rd_n && !wr_n) || (convst != 4'h0 && convst != 4'hF)) viol <= viol + 1;
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int cur_size(input int which);
      case (which)
         0:       return conv_cyc.size();
         1:       return bt_q.size();
         default: return err_cyc.size();
      endcase
   endfunction

   task automatic wait_size(input int which, input int n, input int lim, input string tag);
      int k = 0;
      while (cur_size(which) < n && k < lim) begin
         tick_n(1);
         k++;
      end
      chk(tag, 64'(cur_size(which) >= n), 64'd1);
   endtask

   task automatic check_frame(input int base, input string tag);
      logic [19:0] e;
      for (int i = 0; i < N_CH; i++) begin
         e = {i[2:0], 16'h1000 + 16'(i), (i == N_CH - 1)};
         chk(tag, 64'(bt_q[base+i]), 64'(e));
      end
   endtask

   initial begin
      int nb, be, ov, wb, er;
      // 1: reset, ADCrst pulse, two config writes, idle with en=0
      tick_n(3);
      chk("rst_adcrst", adc_rst, 1);
      chk("rst_strobes", {cs_n, rd_n, wr_n}, 3'b111);
      chk("rst_convst", convst, 0);
      chk("rst_state", state_ff, 0);
      chk("rst_flags", {cfg_done, busy_err, overrun, sample_valid}, 0);
      chk("rst_sample", {sample_data, sample_ch, sample_last}, 0);
      chk("tie_pins", {hw_n, par_n, stby_n}, 3'b101);
      rst = 1'b0;
      chk("adcrst_s0", adc_rst, 1);
      tick_n(3);
      chk("adcrst_s3", adc_rst, 1);
      tick_n(1);
      chk("cfg_hi_start", {adc_rst, cs_n, wr_n, rd_n}, 4'b0001);
      chk("cfg_hi_db", db, 16'h8054);
      tick_n(3);
      chk("cfg_hi_low4", wr_n, 0);
      tick_n(1);
      chk("cfg_hi_gap", {cs_n, wr_n}, 2'b01);
      tick_n(1);
      chk("cfg_lo_start", wr_n, 0);
      chk("cfg_lo_db", db, 16'h03FF);
      tick_n(3);
      chk("cfg_lo_low4", {wr_n, cfg_done}, 2'b00);
      tick_n(1);
      chk("cfg_lo_gap", wr_n, 1);
      tick_n(1);
      chk("cfg_done", {cfg_done, cs_n, state_ff}, {2'b11, 3'd2});
      tick_n(300);
      chk("en0_no_conv", conv_cyc.size(), 0);

      // 2: periodic frames, 8 beats each
      en = 1'b1;
      wait_size(1, 24, 1000, "t2_beats_timeout");
      chk("t2_period01", conv_cyc[1] - conv_cyc[0], SAMPLE_DIV);
      chk("t2_period12", conv_cyc[2] - conv_cyc[1], SAMPLE_DIV);
      check_frame(0, "t2_frame0");
      check_frame(8, "t2_frame1");
      check_frame(16, "t2_frame2");
      chk("t2_no_err", {ovr_cnt[7:0], err_cyc.size()}, 0);

      // 3: Busy never rises -> timeout, no beats, recovery on later tick
      no_busy = 1'b1;
      nb = conv_cyc.size(); be = bt_q.size(); ov = ovr_cnt; wb = wbh_cyc.size(); er = err_cyc.size();
      wait_size(2, er + 1, 500, "t3_err_timeout");
      chk("t3_convst_width", wbh_cyc[wb] - conv_cyc[nb], 4);
      chk("t3_err_latency", err_cyc[er] - wbh_cyc[wb], BUSY_TO + 2);
      chk("t3_err_idle", state_ff, 2);
      chk("t3_no_beats", bt_q.size(), be);
      chk("t3_overrun", ovr_cnt - ov, 1);
      no_busy = 1'b0;
      wait_size(0, nb + 2, 400, "t3_conv_timeout");
      chk("t3_next_tick", conv_cyc[nb+1] - conv_cyc[nb], 2 * SAMPLE_DIV);
      wait_size(1, be + 8, 200, "t3_beats_timeout");
      check_frame(be, "t3_recover");

      // 4: long Busy -> one dropped tick per frame, frames still complete
      busy_hi = 150;
      nb = conv_cyc.size(); be = bt_q.size(); ov = ovr_cnt; er = err_cyc.size();
      wait_size(0, nb + 3, 1000, "t4_conv_timeout");
      tick_n(240);
      chk("t4_period01", conv_cyc[nb+1] - conv_cyc[nb], 2 * SAMPLE_DIV);
      chk("t4_period12", conv_cyc[nb+2] - conv_cyc[nb+1], 2 * SAMPLE_DIV);
      chk("t4_overruns", ovr_cnt - ov, 3);
      chk("t4_beats", bt_q.size() - be, 24);
      chk("t4_no_err", err_cyc.size(), er);
      check_frame(be, "t4_frame0");
      check_frame(be + 16, "t4_frame2");

      // 5: reset mid-READ at ch3
      busy_hi = 10;
      begin
         int k = 0;
         while (!(sample_valid && sample_ch == 3'd2) && k < 600) begin
            tick_n(1);
            k++;
         end
      end
      chk("t5_found_ch2", {sample_valid, sample_ch}, {1'b1, 3'd2});
      tick_n(2);
      chk("t5_in_read_ch3", {state_ff, rd_n}, {3'd6, 1'b0});
      rst = 1'b1;
      tick_n(1);
      chk("t5_abort_strobes", {cs_n, rd_n, wr_n, convst, sample_valid}, {3'b111, 4'h0, 1'b0});
      chk("t5_abort_state", {state_ff, adc_rst, cfg_done}, {3'd0, 1'b1, 1'b0});
      rst = 1'b0;
      tick_n(4);
      chk("t5_recfg", {adc_rst, wr_n, db}, {2'b00, 16'h8054});
      tick_n(10);
      chk("t5_recfg_done", cfg_done, 1);

      // 6: frames after reconfig; tick count per frame when enabled
      be = bt_q.size();
      wait_size(1, be + 16, 600, "t6_beats_timeout");
      check_frame(be, "t6_frame0");
      check_frame(be + 8, "t6_frame1");
`ifdef ADC_TIMESTAMP_EN
      for (int i = 0; i < N_CH; i++) begin
         chk("t6_ts_frame0", bt_ts[be+i], 32'd0);
         chk("t6_ts_frame1", bt_ts[be+N_CH+i], 32'd1);
      end
`endif
      chk("bus_rules", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
